inv_sbox_builder: RTL

INV_SBOX_BUILDER -- requirements
Module: inv_sbox_builder

---
 rtl/inv_sbox_builder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/inv_sbox_builder.sv
// inv_sbox_builder
//   Builds the inverse of a forward S-box that is streamed in one element per
//   accepted beat (beat k carries S[k]), then answers inverse lookups
//   S^-1[y] with a fixed one-cycle latency.
//
//   Duplicate detection: a seen[] bit per value.  A repeated value means the
//   stream is not a permutation, so the builder parks in ERR until clear or
//   reset.  The inverse table itself is never cleared; because lookups are
//   only served in DONE (every seen bit set, every entry rewritten), stale
//   contents from an earlier build can never be observed.
//
// Handshake: valid is a one-way qualifier (there is no ready).  A beat is
//   consumed on the rising edge where valid=1, clear=0 and the FSM is in
//   LOAD.  In DONE/ERR beats are dropped.  lookup_en is likewise a one-way
//   request that is served only in DONE with clear=0; its answer appears as
//   lookup_valid/lookup_data exactly one cycle later.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   valid, V_in    : forward S-box element stream
//   clear          : synchronous restart of the build (wins over valid/lookup)
//   lookup_en      : inverse lookup request, lookup_addr = y
//   lookup_valid   : lookup_data = S^-1[y] this cycle
//   lookup_data    : held when lookup_valid=0
//   table_ready    : full permutation received (state DONE)
//   error          : duplicate value seen (state ERR), sticky
//   load_count     : accepted beats so far, 0..2^MIX_WIDTH
//   o_dbg_state    : FSM state (0=LOAD, 1=DONE, 2=ERR)
module inv_sbox_builder #(
  parameter int MIX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid,
  input  logic [MIX_WIDTH-1:0] V_in,
  input  logic                 clear,
  input  logic                 lookup_en,
  input  logic [MIX_WIDTH-1:0] lookup_addr,
  output logic                 lookup_valid,
  output logic [MIX_WIDTH-1:0] lookup_data,
  output logic                 table_ready,
  output logic                 error,
  output logic [MIX_WIDTH:0]   load_count,
  output logic [1:0]           o_dbg_state
);

  localparam int DEPTH = 1 << MIX_WIDTH;
  localparam logic [MIX_WIDTH:0] LAST_IDX = (MIX_WIDTH+1)'(DEPTH - 1);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_DONE = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [MIX_WIDTH:0]   r_load_count;
  logic [DEPTH-1:0]     r_seen;
  logic [MIX_WIDTH-1:0] r_inv [DEPTH];
  logic                 r_lookup_valid;
  logic [MIX_WIDTH-1:0] r_lookup_data;

  logic w_beat;
  logic w_dup;
  logic w_accept;
  logic w_last;
  logic w_lookup_go;

  // A beat is only considered while loading and not being cleared.
  assign w_beat      = valid & ~clear & (r_state == S_LOAD);
  assign w_dup       = r_seen[V_in];
  assign w_accept    = w_beat & ~w_dup;
  assign w_last      = (r_load_count == LAST_IDX);
  assign w_lookup_go = lookup_en & ~clear & (r_state == S_DONE);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_LOAD;
    else          r_state <= w_next_state;
  end

  // FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_beat && w_dup)         w_next_state = S_ERR;
          else if (w_accept && w_last) w_next_state = S_DONE;
        end
        S_DONE:  w_next_state = S_DONE;
        S_ERR:   w_next_state = S_ERR;
        default: w_next_state = S_LOAD;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    table_ready  = (r_state == S_DONE);
    error        = (r_state == S_ERR);
    o_dbg_state  = r_state;
    load_count   = r_load_count;
    lookup_valid = r_lookup_valid;
    lookup_data  = r_lookup_data;
  end

  // Beat counter and seen bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_count <= '0;
      r_seen       <= '0;
    end else if (clear) begin
      r_load_count <= '0;
      r_seen       <= '0;
    end else if (w_accept) begin
      r_load_count   <= r_load_count + 1'b1;
      r_seen[V_in]   <= 1'b1;
    end
  end

  // Inverse table storage: plain memory, no reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_inv[V_in] <= r_load_count[MIX_WIDTH-1:0];
  end

  // Lookup pipeline: one-cycle read, data held between answers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lookup_valid <= 1'b0;
      r_lookup_data  <= '0;
    end else begin
      r_lookup_valid <= w_lookup_go;
      if (w_lookup_go) r_lookup_data <= r_inv[lookup_addr];
    end
  end

endmodule
